// File: rtl/camera_pkg.sv
// Shared types for the camera frame writer: pixel formats,
// capture state and default frame geometry.
package camera_pkg;

    localparam int DEF_OUT_W = 320;
    localparam int DEF_OUT_H = 240;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic {
        S_SKIP,
        S_WRITE
    } state_t;

    // Keep the top four bits of each channel.
    function automatic rgb444_t rgb565_to_rgb444(input rgb565_t p);
        rgb444_t q;
        q.r = p.r[4:1];
        q.g = p.g[5:2];
        q.b = p.b[4:1];
        return q;
    endfunction

endpackage

// File: rtl/camera_pixel_counter.sv
// Input raster position, write pointer and pixel count for one frame.
// Ports: clk/rst_n; clear closes the frame; advance = pixel seen in
// S_WRITE; keep = store this pixel; ptr = its address; good = frame
// is exactly full (including this cycle's pixel) with no overflow.
module camera_pixel_counter
    import camera_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int OUT_H  = DEF_OUT_H,
    parameter int DECIM  = 2,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic              keep,
    output logic [ADDR_W-1:0] ptr,
    output logic              good
);

    localparam int IN_W = OUT_W * DECIM;
    localparam int IN_H = OUT_H * DECIM;
    localparam int N_IN = IN_W * IN_H;
    localparam int XW   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW   = $clog2(IN_H + 1);
    localparam int CW   = $clog2(N_IN + 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_fin;
    logic          ovf;
    logic          ovf_fin;
    logic          room;
    logic          accept;
    logic          on_grid;
    logic          x_wrap;

    assign room   = cnt != CW'(N_IN);
    assign accept = advance && room;
    assign x_wrap = x == XW'(IN_W - 1);

    generate
        if (DECIM == 1) begin : g_full
            logic unused_pos;
            assign unused_pos = ^{x, y};
            assign on_grid    = 1'b1;
        end else begin : g_half
            assign on_grid = !x[0] && !y[0];
        end
    endgenerate

    assign keep = accept && on_grid;

    // Frame status as it will be once this cycle's pixel is counted,
    // so a pixel coinciding with end-of-frame is included.
    assign cnt_fin = cnt + CW'(accept);
    assign ovf_fin = ovf || (advance && !room);
    assign good    = (cnt_fin == CW'(N_IN)) && !ovf_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            cnt <= '0;
            ptr <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            x   <= '0;
            y   <= '0;
            cnt <= '0;
            ptr <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            ptr <= ptr + ADDR_W'(keep);
            if (x_wrap) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end else if (advance) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/camera_frame_writer.sv
// Stores camera frames (optionally 2:1 decimated, RGB444) into BRAM.
// Ports: p_clock_in/rst_n_in; capture_en_in, pixel_data_in,
// pixel_valid_in, frame_done_in from the byte assembler; bram_*_out
// write port; frame_ok/err pulses, frame_count_out, busy_out status.
module camera_frame_writer
    import camera_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int OUT_H  = DEF_OUT_H,
    parameter int DECIM  = 2,
    parameter int ADDR_W = 17
) (
    input  logic              p_clock_in,
    input  logic              rst_n_in,
    input  logic              capture_en_in,
    input  logic [15:0]       pixel_data_in,
    input  logic              pixel_valid_in,
    input  logic              frame_done_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [11:0]       bram_data_out,
    output logic              bram_we_out,
    output logic              frame_ok_out,
    output logic              frame_err_out,
    output logic [7:0]        frame_count_out,
    output logic              busy_out
);

    generate
        if (DECIM != 1 && DECIM != 2) begin : g_bad_decim
            $error("DECIM must be 1 or 2");
        end
        if ((64'd1 << ADDR_W) < 64'(OUT_W * OUT_H)) begin : g_bad_addr
            $error("ADDR_W too small for OUT_W*OUT_H");
        end
    endgenerate

    state_t            state;
    state_t            state_nx;
    logic              advance;
    logic              keep;
    logic              good;
    logic              ok_nx;
    logic              err_nx;
    logic [ADDR_W-1:0] ptr;

    assign advance = pixel_valid_in && (state == S_WRITE);

    camera_pixel_counter #(
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .DECIM  (DECIM),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk     (p_clock_in),
        .rst_n   (rst_n_in),
        .clear   (frame_done_in),
        .advance (advance),
        .keep    (keep),
        .ptr     (ptr),
        .good    (good)
    );

    always_ff @(posedge p_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_SKIP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        if (frame_done_in) begin
            state_nx = capture_en_in ? S_WRITE : S_SKIP;
            if (state == S_WRITE) begin
                ok_nx  = good;
                err_nx = !good;
            end
        end
    end

    always_ff @(posedge p_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_addr_out   <= '0;
            bram_data_out   <= '0;
            bram_we_out     <= 1'b0;
            frame_ok_out    <= 1'b0;
            frame_err_out   <= 1'b0;
            frame_count_out <= '0;
        end else begin
            bram_we_out   <= keep;
            frame_ok_out  <= ok_nx;
            frame_err_out <= err_nx;
            if (keep) begin
                bram_addr_out <= ptr;
                bram_data_out <= rgb565_to_rgb444(pixel_data_in);
            end
            if (ok_nx) begin
                frame_count_out <= frame_count_out + 1'b1;
            end
        end
    end

    assign busy_out = state == S_WRITE;

endmodule
